seq_pattern_tx: RTL

Serial pattern transmitter: the source side of the team's serial bit-sequence detectors.
- Captures a pattern word of up to PAT_W bits on a start request.
- Emits the pattern MSB-first, one bit per clock, on a serial line with a qualifying valid strobe.
- Optionally repeats the pattern back-to-back, then pulses done.
- Drives detector benches and the serial test-stimulus path.

---
 rtl/seq_pkg.sv | 22 ++
 rtl/seq_tx_shifter.sv | 81 ++++++++
 rtl/seq_pattern_tx.sv | 125 ++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pkg
//  Description : Shared constants for the serial bit-sequence family
//                (pattern transmitter and detectors): state encoding and
//                default sizing of pattern, length and repeat fields.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

    // Default sizing shared by the transmitter and the detector blocks
    localparam int SEQ_PAT_W = 8;
    localparam int SEQ_LEN_W = 4;
    localparam int SEQ_CNT_W = 4;

    // Transmitter state encoding
    localparam logic [1:0] SEQ_IDLE = 2'b00;
    localparam logic [1:0] SEQ_SEND = 2'b01;
    localparam logic [1:0] SEQ_DONE = 2'b10;

endpackage
`default_nettype wire

// File: rtl/seq_tx_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : seq_tx_shifter
//  Description : Captured pattern store for seq_pattern_tx. Holds the
//                pattern and clamped length, tracks the index of the bit
//                currently on the line and selects the bit that should be
//                presented after the next clock edge (MSB-first).
//  Ports       : clk       - system clock
//                reset     - asynchronous active-high reset
//                load_i    - capture pattern_i / len_i this edge
//                adv_i     - step the bit counter this edge
//                pattern_i - pattern word to capture
//                len_i     - requested length (clamped to PAT_W)
//                bit_o     - bit to drive on the line after this edge
//                last_o    - current bit is the last of a pass
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_tx_shifter
    import seq_pkg::*;
#(
    parameter int PAT_W = SEQ_PAT_W,
    parameter int LEN_W = SEQ_LEN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             adv_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             bit_o,
    output logic             last_o
);

    localparam logic [LEN_W-1:0] C_PAT_LEN = LEN_W'(PAT_W);
    localparam logic [LEN_W-1:0] C_ONE     = LEN_W'(1);

    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_d;
    logic [LEN_W-1:0] len_c;
    logic [LEN_W-1:0] idx;
    logic             last;

    assign len_c  = (len_i > C_PAT_LEN) ? C_PAT_LEN : len_i;
    assign last   = (cnt_q == (len_q - C_ONE));
    assign last_o = last;

    // Counter wraps at the pass boundary so the captured pattern replays.
    assign cnt_d  = last ? '0 : (cnt_q + C_ONE);

    // On a load the first bit comes straight from the inputs so it can be
    // registered onto the line in the same edge that captures the pattern.
    always_comb begin
        idx   = '0;
        bit_o = 1'b0;
        if (load_i) begin
            idx   = len_c - C_ONE;
            bit_o = |(pattern_i & (PAT_W'(1) << idx));
        end else begin
            idx   = len_q - C_ONE - cnt_d;
            bit_o = |(pat_q & (PAT_W'(1) << idx));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_q <= '0;
            len_q <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            pat_q <= pattern_i;
            len_q <= len_c;
            cnt_q <= '0;
        end else if (adv_i) begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pattern_tx
//  Description : Serial pattern transmitter. Captures a pattern on start,
//                sends it MSB-first one bit per clock with a valid strobe,
//                repeats it rep extra times back-to-back, then pulses done.
//  Ports       : clk     - system clock, rising edge
//                reset   - asynchronous active-high reset
//                start   - transmit request (IDLE only)
//                pattern - bits to send, bit len-1 first
//                len     - pattern length 1..PAT_W (0 ignored, >PAT_W clamped)
//                rep     - extra passes (total passes = rep+1)
//                abort   - cancel an in-progress transmission
//                x       - serial data bit (0 when not valid)
//                valid   - x carries a pattern bit
//                busy    - transmission in progress
//                done    - one-cycle completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int PAT_W = SEQ_PAT_W,
    parameter int LEN_W = SEQ_LEN_W,
    parameter int CNT_W = SEQ_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] rep,
    input  logic             abort,
    output logic             x,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] pass_q;
    logic [CNT_W-1:0] rep_q;
    logic             x_q,     x_d;
    logic             valid_q, valid_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    logic             load;
    logic             sending;
    logic             sh_bit;
    logic             sh_last;
    logic             final_bit;

    assign load      = (state_q == SEQ_IDLE) && start && (len != '0);
    assign sending   = (state_q == SEQ_SEND);
    assign final_bit = sending && sh_last && (pass_q == rep_q);

    seq_tx_shifter #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load_i    (load),
        .adv_i     (sending),
        .pattern_i (pattern),
        .len_i     (len),
        .bit_o     (sh_bit),
        .last_o    (sh_last)
    );

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            SEQ_IDLE: if (load)           state_d = SEQ_SEND;
            SEQ_SEND: if (abort)          state_d = SEQ_IDLE;
                      else if (final_bit) state_d = SEQ_DONE;
            SEQ_DONE:                     state_d = SEQ_IDLE;
            default:                      state_d = SEQ_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered in
    // the same cycle the state they describe becomes current.
    always_comb begin
        valid_d = (state_d == SEQ_SEND);
        busy_d  = (state_d == SEQ_SEND);
        done_d  = (state_d == SEQ_DONE);
        x_d     = valid_d & sh_bit;
    end

    // State, pass counter and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SEQ_IDLE;
            pass_q  <= '0;
            rep_q   <= '0;
            x_q     <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (load) begin
                rep_q  <= rep;
                pass_q <= '0;
            end else if (sending && sh_last) begin
                pass_q <= pass_q + CNT_W'(1);
            end
        end
    end

    assign x     = x_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
`default_nettype wire
